// File: rtl/gh_fifo_pkg.sv
// Shared constants and pointer helper for the FWFT read adapter.
// Buffer depth and occupancy width live here so top and storage agree.
package gh_fifo_pkg;

  localparam int unsigned BUF_DEPTH = 3;
  localparam int unsigned OCC_W     = 2;

  localparam logic [OCC_W-1:0] OCC_ZERO  = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W:0]   DEPTH_CNT = 3'd3;

  // Pointer wraps modulo the 3-entry depth; the unused code 3 folds back to 0.
  function automatic logic [OCC_W-1:0] ptr_inc(input logic [OCC_W-1:0] p);
    case (p)
      2'd0:    ptr_inc = 2'd1;
      2'd1:    ptr_inc = 2'd2;
      default: ptr_inc = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/gh_fifo_rd_fwft_if.sv
// FIFO read-side and downstream valid/ready stream bundle for gh_fifo_rd_fwft.
// master = adapter side, slave = FIFO/consumer side.
interface gh_fifo_rd_fwft_if #(parameter int data_width = 8);

  logic                  f_empty;
  logic                  f_RD;
  logic [data_width-1:0] f_Q;
  logic [data_width-1:0] Q;
  logic                  Q_valid;
  logic                  Q_ready;

  modport master (input f_empty, f_Q, Q_ready, output f_RD, Q, Q_valid);
  modport slave  (output f_empty, f_Q, Q_ready, input f_RD, Q, Q_valid);

endinterface

// File: rtl/gh_fifo_rd_buf.sv
// 3-entry circular storage with head/tail pointers; occupancy is tracked by the parent.
// Read data is the entry under the head pointer.
module gh_fifo_rd_buf
  import gh_fifo_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srst,
  input  logic                  wr_en_i,
  input  logic [data_width-1:0] wr_data_i,
  input  logic                  pop_i,
  output logic [data_width-1:0] rd_data_o
);

  logic [data_width-1:0] mem_q [BUF_DEPTH];
  logic [OCC_W-1:0]      head_q;
  logic [OCC_W-1:0]      tail_q;

  // Storage and pointer update; flush only rewinds pointers, reset also zeroes data.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= OCC_ZERO;
      tail_q <= OCC_ZERO;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (srst) begin
      head_q <= OCC_ZERO;
      tail_q <= OCC_ZERO;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_en_i && (tail_q == OCC_W'(i))) begin
          mem_q[i] <= wr_data_i;
        end
      end
      if (wr_en_i) begin
        tail_q <= ptr_inc(tail_q);
      end
      if (pop_i) begin
        head_q <= ptr_inc(head_q);
      end
    end
  end

  // Head entry select.
  always_comb begin
    case (head_q)
      2'd0:    rd_data_o = mem_q[0];
      2'd1:    rd_data_o = mem_q[1];
      2'd2:    rd_data_o = mem_q[2];
      default: rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/gh_fifo_rd_fwft.sv
// First-word-fall-through adapter: latency-1 FIFO strobe port to a valid/ready stream.
// Optional macro GH_FIFO_RD_FWFT_CNT_EN adds the rd_count occupancy output.
module gh_fifo_rd_fwft
  import gh_fifo_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               srst,
`ifdef GH_FIFO_RD_FWFT_CNT_EN
  output logic [OCC_W-1:0]   rd_count,
`endif
  gh_fifo_rd_fwft_if.master  bus
);

  logic [OCC_W-1:0]      occ_q;
  logic [OCC_W-1:0]      occ_d;
  logic                  pend_q;
  logic                  pend_d;
  logic [OCC_W:0]        inflight_s;
  logic                  rd_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  push_s;
  logic [data_width-1:0] q_s;

  // Read issue counts words in flight so the buffer can never overflow;
  // Q_ready deliberately does not feed rd_s.
  always_comb begin
    inflight_s = {1'b0, occ_q} + {{OCC_W{1'b0}}, pend_q};
    rd_s       = !bus.f_empty && !srst && !rst && (inflight_s < DEPTH_CNT);
    valid_s    = (occ_q != OCC_ZERO);
    pop_s      = valid_s && bus.Q_ready;
    push_s     = pend_q && !srst;
    pend_d     = rd_s;
    if (srst) begin
      occ_d = OCC_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Occupancy and pending-read registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_ZERO;
      pend_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= pend_d;
    end
  end

  gh_fifo_rd_buf #(
    .data_width (data_width)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .srst      (srst),
    .wr_en_i   (push_s),
    .wr_data_i (bus.f_Q),
    .pop_i     (pop_s),
    .rd_data_o (q_s)
  );

  assign bus.f_RD    = rd_s;
  assign bus.Q_valid = valid_s;
  assign bus.Q       = q_s;

`ifdef GH_FIFO_RD_FWFT_CNT_EN
  assign rd_count = occ_q;
`endif

endmodule

// File: tb/tb_gh_fifo_rd_fwft.sv
// Self-checking bench for gh_fifo_rd_fwft: queue-based FIFO source and stream scoreboard.
module tb_gh_fifo_rd_fwft;

  logic clk = 1'b0;
  logic rst;
  logic srst;
`ifdef GH_FIFO_RD_FWFT_CNT_EN
  logic [1:0] rd_count;
`endif

  gh_fifo_rd_fwft_if #(.data_width(8)) bus ();

  gh_fifo_rd_fwft #(.data_width(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .srst     (srst),
`ifdef GH_FIFO_RD_FWFT_CNT_EN
    .rd_count (rd_count),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] src[$];      // words still inside the upstream FIFO
  logic [7:0] exp_q[$];    // words captured by the adapter, not yet consumed
  logic [7:0] out_log[$];  // words consumed downstream
  int         pop_cyc[$];
  logic [7:0] words[$];    // copy of the words loaded for the current test
  bit         inflight;
  logic [7:0] inflight_w;
  int         rd_pulses;
  int         rd_while_empty;

  // One clock: drive at negedge, check before the edge, advance the model at the edge.
  task automatic step(input bit force_empty, input bit rdy, input bit sr);
    bit exp_rd;
    bit do_pop;
    @(negedge clk);
    srst         = sr;
    bus.Q_ready  = rdy;
    bus.f_empty  = force_empty || (src.size() == 0);
    #1;
    exp_rd = !bus.f_empty && !sr && !rst && ((exp_q.size() + int'(inflight)) < 3);
    n_checks++;
    if (bus.f_RD !== exp_rd) begin
      n_fail++;
      $display("FAIL f_RD cyc=%0d got=%b exp=%b", cyc, bus.f_RD, exp_rd);
    end
    if (bus.f_RD === 1'b1) rd_pulses++;
    if (bus.f_RD === 1'b1 && bus.f_empty) rd_while_empty++;
    n_checks++;
    if (bus.Q_valid !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL Q_valid cyc=%0d got=%b exp=%b", cyc, bus.Q_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      if (bus.Q !== exp_q[0]) begin
        n_fail++;
        $display("FAIL Q cyc=%0d got=%h exp=%h", cyc, bus.Q, exp_q[0]);
      end
    end
`ifdef GH_FIFO_RD_FWFT_CNT_EN
    n_checks++;
    if (rd_count !== 2'(exp_q.size())) begin
      n_fail++;
      $display("FAIL rd_count cyc=%0d got=%0d exp=%0d", cyc, rd_count, exp_q.size());
    end
`endif
    do_pop = (exp_q.size() != 0) && rdy;
    @(posedge clk);
    if (rst || sr) begin
      exp_q.delete();
      inflight = 0;
    end else begin
      if (do_pop) begin
        out_log.push_back(exp_q.pop_front());
        pop_cyc.push_back(cyc);
      end
      if (inflight) exp_q.push_back(inflight_w);
      inflight = 0;
      if (exp_rd) begin
        inflight_w = src.pop_front();
        inflight   = 1;
      end
    end
    cyc++;
    #1;
    bus.f_Q = inflight ? inflight_w : 8'($urandom);
  endtask

  task automatic quiesce();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    src.delete();
    words.delete();
    out_log.delete();
    pop_cyc.delete();
    rd_pulses      = 0;
    rd_while_empty = 0;
  endtask

  task automatic load(input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      src.push_back(w);
      words.push_back(w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (bus.Q_valid !== 1'b0 || bus.Q !== 8'h00 || bus.f_RD !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got valid=%b Q=%h rd=%b exp 0/00/0", bus.Q_valid, bus.Q, bus.f_RD);
    end
    step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_first_word();
    int c0;
    quiesce();
    src = '{8'h11, 8'h22, 8'h33};
    c0  = cyc;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (out_log.size() != 3 || out_log[0] !== 8'h11 || out_log[1] !== 8'h22 || out_log[2] !== 8'h33) begin
      n_fail++;
      $display("FAIL first_word_data got n=%0d exp 11,22,33", out_log.size());
    end
    n_checks++;
    if (pop_cyc.size() != 3 || pop_cyc[0] != c0 + 2 || pop_cyc[1] != c0 + 3 || pop_cyc[2] != c0 + 4) begin
      n_fail++;
      $display("FAIL first_word_latency got first=%0d exp=%0d", (pop_cyc.size() > 0) ? pop_cyc[0] - c0 : -1, 2);
    end
  endtask

  task automatic test_fill_and_drain();
    quiesce();
    load(10);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rd_pulses != 3) begin
      n_fail++;
      $display("FAIL fill_rd_pulses got=%0d exp=3", rd_pulses);
    end
    n_checks++;
    if (bus.Q !== words[0] || bus.Q_valid !== 1'b1 || bus.f_RD !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_hold got Q=%h v=%b rd=%b exp Q=%h v=1 rd=0", bus.Q, bus.Q_valid, bus.f_RD, words[0]);
    end
    load(10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (out_log.size() != 10 || pop_cyc[9] - pop_cyc[0] != 9) begin
      n_fail++;
      $display("FAIL drain_rate got pops=%0d exp=10 back-to-back", out_log.size());
    end
    for (int i = 0; i < out_log.size(); i++) begin
      n_checks++;
      if (out_log[i] !== words[i]) begin
        n_fail++;
        $display("FAIL drain_order idx=%0d got=%h exp=%h", i, out_log[i], words[i]);
      end
    end
  endtask

  task automatic test_srst();
    quiesce();
    load(8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.Q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL srst_flush got valid=%b exp=0", bus.Q_valid);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (out_log.size() == 0 || out_log[0] !== words[3]) begin
      n_fail++;
      $display("FAIL srst_next_word got=%h exp=%h", (out_log.size() > 0) ? out_log[0] : 8'hxx, words[3]);
    end
  endtask

  task automatic test_rst_mid();
    quiesce();
    load(8);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (out_log.size() != 0 || bus.Q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop got pops=%0d valid=%b exp 0/0", out_log.size(), bus.Q_valid);
    end
  endtask

  task automatic test_toggle_random();
    quiesce();
    load(30);
    for (int i = 0; i < 200; i++) step(bit'(i % 2), bit'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (rd_while_empty != 0) begin
      n_fail++;
      $display("FAIL rd_while_empty got=%0d exp=0", rd_while_empty);
    end
    n_checks++;
    if (out_log.size() != 30) begin
      n_fail++;
      $display("FAIL toggle_count got=%0d exp=30", out_log.size());
    end
    for (int i = 0; i < out_log.size() && i < 30; i++) begin
      n_checks++;
      if (out_log[i] !== words[i]) begin
        n_fail++;
        $display("FAIL toggle_order idx=%0d got=%h exp=%h", i, out_log[i], words[i]);
      end
    end
  endtask

`ifdef GH_FIFO_RD_FWFT_CNT_EN
  task automatic test_count();
    logic [1:0] seen[$];
    logic [1:0] req[5];
    req = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    quiesce();
    load(10);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      seen.push_back(rd_count);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (seen[i] !== req[i]) begin
        n_fail++;
        $display("FAIL rd_count_fill idx=%0d got=%0d exp=%0d", i, seen[i], req[i]);
      end
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (rd_count !== 2'd0) begin
      n_fail++;
      $display("FAIL rd_count_drain got=%0d exp=0", rd_count);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    srst        = 1'b0;
    bus.f_empty = 1'b1;
    bus.Q_ready = 1'b0;
    bus.f_Q     = 8'h00;
    inflight    = 0;
    inflight_w  = 8'h00;
    test_reset();
    test_first_word();
    test_fill_and_drain();
    test_srst();
    test_rst_mid();
    test_toggle_random();
`ifdef GH_FIFO_RD_FWFT_CNT_EN
    test_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gh_fifo_rd_fwft.md
GH_FIFO_RD_FWFT -- requirements
Module: gh_fifo_rd_fwft

Interface
REQ-001 SHALL have parameter: data_width, default 8, width of the FIFO read data and output data.
REQ-002 SHALL have port: clk  in  1  single clock for all logic, rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: srst  in  1  synchronous flush, active-high; clears buffered data.
REQ-005 SHALL have port: f_empty  in  1  empty flag from the FIFO read side.
REQ-006 SHALL have port: f_RD  out  1  read strobe to the FIFO.
REQ-007 SHALL have port: f_Q  in  data_width  FIFO read data, valid the cycle after an accepted f_RD.
REQ-008 SHALL have port: Q  out  data_width  head-of-stream data (first-word-fall-through).
REQ-009 SHALL have port: Q_valid  out  1  Q holds valid data.
REQ-010 SHALL have port: Q_ready  in  1  downstream accepts Q this cycle.

Function
REQ-011 SHALL convert the FIFO strobe/latency-1 read port into a valid/ready stream with a 3-entry internal buffer (occ, 0..3) and a registered pending-read flag (pend).
REQ-012 SHALL drive f_RD = !f_empty & !srst & !rst & ((occ + pend) < 3), decoded from registers and f_empty only, with no combinational path from Q_ready.
REQ-013 SHALL set pend on the next edge to f_RD, and write f_Q into the buffer tail on the edge following the cycle pend=1.
REQ-014 SHALL treat pop = Q_valid & Q_ready, and Q_valid = (occ != 0); Q SHALL show the oldest entry and stay stable while Q_valid=1 and Q_ready=0.
REQ-015 SHALL support push and pop in the same cycle, leaving occ unchanged and preserving strict FIFO order.
REQ-016 SHALL reach occ=3 only when pend arrives while occ=2 and there is no pop; overflow is impossible by construction of REQ-012.
REQ-017 SHALL sustain one word per clock when Q_ready=1 continuously and f_empty=0 (steady state occ=1, pend=1).
REQ-018 SHALL have first-word latency from an f_empty 1->0 transition to Q_valid=1 of exactly 2 clocks (RD issue edge, data capture edge).
REQ-019 SHALL ignore Q_ready when Q_valid=0, and hold Q_valid=0 with occ=0 when the FIFO stays empty.
REQ-020 SHALL, on srst=1, clear occ and pend on the next edge and discard any word returning from a read issued in the srst cycle or before it.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, set occ=0, pend=0, Q_valid=0 and f_RD=0; Q SHALL be all zeros.
REQ-022 SHALL, on rst asserted mid-transfer, drop buffered and in-flight words without emitting them; rst SHALL take priority over srst.

Configuration
REQ-023 SHALL, with macro GH_FIFO_RD_FWFT_CNT_EN defined, add output port rd_count [1:0] equal to registered occ, reset to 0.
REQ-024 SHALL, without GH_FIFO_RD_FWFT_CNT_EN, have no rd_count port, with all other behaviour identical.

Structure
REQ-025 SHALL place the buffer depth constant (3) and the occupancy width constant (2) in shared package gh_fifo_pkg.
REQ-026 SHALL implement the 3-entry storage as sub-module gh_fifo_rd_buf (head/tail pointers, write and pop ports); the occupancy and pend control SHALL remain in the top level.

Verification
REQ-027 SHALL have a test: rst, then f_empty=0 with FIFO data 0x11,0x22,0x33 and Q_ready=1 -> Q_valid rises 2 clocks after f_empty falls; Q=0x11,0x22,0x33 on consecutive cycles.
REQ-028 SHALL have a test: Q_ready=0 with FIFO non-empty -> exactly 3 f_RD pulses, occ=3, f_RD held 0, and Q stable at the first word.
REQ-029 SHALL have a test: from occ=3, Q_ready=1 for 10 cycles with FIFO non-empty -> one pop per cycle, no gaps, no loss, and order preserved.
REQ-030 SHALL have a test: srst pulse while pend=1 and occ=2 -> next cycle Q_valid=0 and occ=0; the returning word is not emitted and the following word is the next FIFO entry.
REQ-031 SHALL have a test: f_empty toggling every cycle with random Q_ready -> output sequence equals the FIFO write sequence, and f_RD is never asserted while f_empty=1.
REQ-032 SHALL have a test with GH_FIFO_RD_FWFT_CNT_EN defined: rd_count tracks 0,1,2,3 during the REQ-028 fill and returns to 0 after drain.
